// File: rtl/if_fetch_pkg.sv
// ============================================================================
//  Module      : if_fetch_pkg
//  Description : Shared fetch-stage constants and FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_fetch_pkg;

  localparam int unsigned C_INST_W = 32;
  localparam logic [C_INST_W-1:0] C_NOP = 32'h0000_0013;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/if_fetch.sv
// ============================================================================
//  Module      : if_fetch
//  Description : Byte-serial instruction fetch; assembles four little-endian
//                bytes into one word and holds it until decode accepts it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch
  import if_fetch_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_in,
  input  logic                jump_en_in,
  input  logic [31:0]         jump_addr_in,
  output logic                mem_req_out,
  output logic [31:0]         mem_addr_out,
  input  logic                mem_ack_in,
  input  logic [7:0]          mem_data_in,
  output logic [C_INST_W-1:0] inst_out,
  output logic [31:0]         pc_out,
  output logic                inst_valid_out
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [1:0]   r_cnt;
  logic [23:0]  r_buf;

  // r_cnt is always zero in HOLD, so one adder serves both states.
  assign mem_req_out  = (r_state == ST_FETCH);
  assign mem_addr_out = r_pc + {30'd0, r_cnt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_FETCH;
      r_pc           <= 32'd0;
      r_cnt          <= 2'd0;
      r_buf          <= 24'd0;
      inst_out       <= C_NOP;
      pc_out         <= 32'd0;
      inst_valid_out <= 1'b0;
    end else if (jump_en_in) begin
      // Redirect wins over any ack, completion or stall on the same edge.
      r_state        <= ST_FETCH;
      r_pc           <= jump_addr_in & 32'hFFFF_FFFC;
      r_cnt          <= 2'd0;
      r_buf          <= 24'd0;
      inst_out       <= C_NOP;
      inst_valid_out <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (mem_ack_in) begin
            if (r_cnt == 2'd3) begin
              inst_out       <= {mem_data_in, r_buf};
              pc_out         <= r_pc;
              inst_valid_out <= 1'b1;
              r_pc           <= r_pc + 32'd4;
              r_cnt          <= 2'd0;
              r_buf          <= 24'd0;
              r_state        <= ST_HOLD;
            end else begin
              case (r_cnt)
                2'd0:    r_buf[7:0]   <= mem_data_in;
                2'd1:    r_buf[15:8]  <= mem_data_in;
                default: r_buf[23:16] <= mem_data_in;
              endcase
              r_cnt <= r_cnt + 2'd1;
            end
          end
        end
        ST_HOLD: begin
          if (!stall_in) begin
            inst_out       <= C_NOP;
            inst_valid_out <= 1'b0;
            r_state        <= ST_FETCH;
          end
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// ============================================================================
//  Module      : tb_if_fetch
//  Description : Directed and randomized bench for if_fetch with a reference
//                model that fetches whole words from a sparse memory image.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_in = 1'b0;
  logic        jump_en_in = 1'b0;
  logic [31:0] jump_addr_in = 32'd0;
  logic        mem_ack_in = 1'b0;
  logic [7:0]  mem_data_in;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_valid_out;

  logic [7:0] dmem [logic [31:0]];
  int n_cmp = 0;
  int n_err = 0;

  if_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .stall_in       (stall_in),
    .jump_en_in     (jump_en_in),
    .jump_addr_in   (jump_addr_in),
    .mem_req_out    (mem_req_out),
    .mem_addr_out   (mem_addr_out),
    .mem_ack_in     (mem_ack_in),
    .mem_data_in    (mem_data_in),
    .inst_out       (inst_out),
    .pc_out         (pc_out),
    .inst_valid_out (inst_valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (dmem.exists(a)) return dmem[a];
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  // Bus carries inverted garbage when no ack, so unacked captures show up.
  assign mem_data_in = mem_ack_in ? mem_byte(mem_addr_out) : ~mem_byte(mem_addr_out);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: counts acked bytes, then reads the whole word from memory.
  logic [31:0] m_pc    = 32'd0;
  logic [31:0] m_inst  = C_NOP;
  logic [31:0] m_pcout = 32'd0;
  int          m_cnt   = 0;
  bit          m_hold  = 1'b0;
  bit          m_valid = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 32'd0; m_cnt = 0; m_hold = 1'b0;
      m_valid = 1'b0; m_inst = C_NOP; m_pcout = 32'd0;
    end else if (jump_en_in) begin
      m_pc = {jump_addr_in[31:2], 2'b00};
      m_cnt = 0; m_hold = 1'b0; m_valid = 1'b0; m_inst = C_NOP;
    end else if (!m_hold) begin
      if (mem_ack_in) begin
        m_cnt++;
        if (m_cnt == 4) begin
          m_inst  = {mem_byte(m_pc + 32'd3), mem_byte(m_pc + 32'd2),
                     mem_byte(m_pc + 32'd1), mem_byte(m_pc)};
          m_pcout = m_pc;
          m_valid = 1'b1;
          m_pc    = m_pc + 32'd4;
          m_cnt   = 0;
          m_hold  = 1'b1;
        end
      end
    end else if (!stall_in) begin
      m_hold = 1'b0; m_valid = 1'b0; m_inst = C_NOP;
    end
  end

  always @(negedge clk) begin
    chk("m_req",   {31'd0, mem_req_out},    {31'd0, !m_hold});
    chk("m_addr",  mem_addr_out,            m_pc + m_cnt);
    chk("m_valid", {31'd0, inst_valid_out}, {31'd0, m_valid});
    chk("m_inst",  inst_out,                m_inst);
    chk("m_pcout", pc_out,                  m_pcout);
  end

  initial begin
    dmem[32'h0]  = 8'h13; dmem[32'h1]  = 8'h00; dmem[32'h2]  = 8'h00; dmem[32'h3]  = 8'h00;
    dmem[32'h10] = 8'hB3; dmem[32'h11] = 8'h00; dmem[32'h12] = 8'h21; dmem[32'h13] = 8'h00;
    rst = 1'b1;
    #2;
    chk("rst_req",   {31'd0, mem_req_out},    32'd1);
    chk("rst_addr",  mem_addr_out,            32'd0);
    chk("rst_valid", {31'd0, inst_valid_out}, 32'd0);
    chk("rst_inst",  inst_out,                32'h13);
    chk("rst_pc",    pc_out,                  32'd0);
    step();
    rst = 1'b0;
    mem_ack_in = 1'b1;

    // Basic fetch of a NOP from address 0
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", mem_addr_out, i);
      step();
    end
    chk("t1_valid", {31'd0, inst_valid_out}, 32'd1);
    chk("t1_inst",  inst_out,                32'h13);
    chk("t1_pc",    pc_out,                  32'd0);
    chk("t1_req",   {31'd0, mem_req_out},    32'd0);
    step();
    chk("t1_once",  {31'd0, inst_valid_out}, 32'd0);
    chk("t1_next",  mem_addr_out,            32'd4);

    // Stalled hold at 0x10
    jump_en_in = 1'b1; jump_addr_in = 32'h10;
    step();
    jump_en_in = 1'b0; stall_in = 1'b1;
    chk("t2_addr", mem_addr_out, 32'h10);
    repeat (4) step();
    for (int i = 0; i < 4; i++) begin
      chk("t2_valid", {31'd0, inst_valid_out}, 32'd1);
      chk("t2_inst",  inst_out,                32'h002100B3);
      chk("t2_req",   {31'd0, mem_req_out},    32'd0);
      if (i == 3) stall_in = 1'b0;
      step();
    end
    chk("t2_release", {31'd0, inst_valid_out}, 32'd0);

    // Redirect mid-fetch with a simultaneous ack
    repeat (2) step();
    chk("t3_cnt2", mem_addr_out, 32'h16);
    jump_en_in = 1'b1; jump_addr_in = 32'h103;
    step();
    jump_en_in = 1'b0;
    chk("t3_addr",  mem_addr_out,            32'h100);
    chk("t3_novld", {31'd0, inst_valid_out}, 32'd0);
    repeat (4) step();
    chk("t3_valid", {31'd0, inst_valid_out}, 32'd1);
    chk("t3_pc",    pc_out,                  32'h100);

    // PC wrap at the top of the address space
    jump_en_in = 1'b1; jump_addr_in = 32'hFFFF_FFFC;
    step();
    jump_en_in = 1'b0;
    chk("t4_addr",  mem_addr_out,            32'hFFFF_FFFC);
    chk("t4_novld", {31'd0, inst_valid_out}, 32'd0);
    repeat (4) step();
    chk("t4_valid", {31'd0, inst_valid_out}, 32'd1);
    chk("t4_pc",    pc_out,                  32'hFFFF_FFFC);
    step();
    chk("t4_wrap",  mem_addr_out,            32'd0);
    chk("t4_req",   {31'd0, mem_req_out},    32'd1);

    // Asynchronous reset during a partial fetch
    repeat (2) step();
    chk("t5_cnt2", mem_addr_out, 32'd2);
    #3 rst = 1'b1;
    #1;
    chk("t5_req",   {31'd0, mem_req_out},    32'd1);
    chk("t5_addr",  mem_addr_out,            32'd0);
    chk("t5_valid", {31'd0, inst_valid_out}, 32'd0);
    chk("t5_inst",  inst_out,                32'h13);
    chk("t5_pc",    pc_out,                  32'd0);
    step();
    rst = 1'b0;
    chk("t5_fresh", mem_addr_out, 32'd0);
    repeat (4) step();
    chk("t5_fvalid", {31'd0, inst_valid_out}, 32'd1);
    chk("t5_finst",  inst_out,                32'h13);

    // Completion edge coinciding with a redirect
    step();
    repeat (3) step();
    jump_en_in = 1'b1; jump_addr_in = 32'h200;
    step();
    jump_en_in = 1'b0;
    chk("t6_novld", {31'd0, inst_valid_out}, 32'd0);
    chk("t6_addr",  mem_addr_out,            32'h200);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      mem_ack_in   = ($urandom_range(0, 9) < 7);
      stall_in     = $urandom_range(0, 1) == 1;
      jump_en_in   = ($urandom_range(0, 19) == 0);
      jump_addr_in = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : $urandom;
      if ($urandom_range(0, 299) == 0) begin
        #3 rst = 1'b1;
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
